seg_scan_counter: RTL and testbench
===================================

SEG_SCAN_COUNTER -- requirements
Module: seg_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 12000, clk_in cycles per digit scan slot (>=2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, cycles at slot start with all digits deselected (< REFRESH_DIV).
REQ-004 SHALL have parameter TICK_DIV, default 12000000, clk_in cycles per count increment (>=1).
REQ-005 SHALL have parameter HEX_MODE, default 0: 0 = each digit base 10, 1 = base 16.
REQ-006 SHALL have parameter ACTIVE_LOW, default 1: 1 = digit_select and led_segments are active-low, 0 = active-high.
REQ-007 SHALL have ports: clk_in input 1 (sole clock); rst_n_in input 1 (reset, asynchronous, active-low).
REQ-008 SHALL have ports: en_in input 1 (count enable); clear_in input 1 (sync clear); load_in input 1 (sync load); load_value input 4*DIGITS (per-digit load nibbles, digit 0 in [3:0]); dp_in input DIGITS (decimal point per digit).
REQ-009 SHALL have ports: digit_select output DIGITS (bit i drives digit i, digit 0 least significant); led_segments output 8 ({a,b,c,d,e,f,g,dp}); count_out output 4*DIGITS (current value); overflow_out output 1 (wrap pulse).

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at wrap, scan index SHALL advance 0,1,..,DIGITS-1,0.
REQ-011 While refresh counter < BLANK_CYCLES, all digits SHALL be deselected and all segments off.
REQ-012 Otherwise exactly one digit_select bit (the scan index) SHALL be asserted, with led_segments showing that digit's nibble glyph plus its dp_in bit.
REQ-013 digit_select and led_segments SHALL be registered, one cycle behind the refresh counter/scan index.
REQ-014 Glyphs: 0-9 standard; A,b,C,d,E,F for 10-15; in HEX_MODE=0 nibbles 10-15 (loadable) SHALL display blank.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 only while en_in=1, hold while en_in=0; an increment occurs on the cycle it wraps.
REQ-016 Increment SHALL be ripple per digit: digit at base-1 becomes 0 and carries; base = 10 or 16 per HEX_MODE.
REQ-017 Increment from all digits at base-1 SHALL yield all zeros and assert overflow_out for exactly one cycle.
REQ-018 Priority SHALL be clear_in > load_in > increment; clear zeroes value and tick counter; load writes load_value, resets tick counter, no overflow pulse.
REQ-019 In HEX_MODE=0, loaded nibbles >9 SHALL be stored as-is; next increment on such a digit SHALL wrap it to 0 with carry.
REQ-020 clear_in/load_in SHALL not disturb refresh counter or scan index.
REQ-021 count_out SHALL reflect the value register with zero latency from its update.

Reset
REQ-022 On rst_n_in=0, asynchronously: value, tick counter, refresh counter, scan index = 0; overflow_out = 0; digit_select and led_segments = inactive level (all 1 if ACTIVE_LOW=1, else all 0).
REQ-023 Deassertion mid-slot SHALL restart at scan index 0, refresh counter 0 (blanking slot first).

Configuration
REQ-024 Macro SEG_LEADING_ZERO_BLANK_EN, when defined: any zero digit more significant than the highest nonzero digit SHALL display blank (dp_in still shown); digit 0 always displayed.
REQ-025 Without SEG_LEADING_ZERO_BLANK_EN all digits SHALL display their glyphs, including leading zeros.

Verification (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, TICK_DIV=2, ACTIVE_LOW=1)
REQ-026 Reset release, value 0 -> digit_select cycles 1111,1110,... through 0111, one digit per 4 cycles with 1111 during each slot's first cycle; led_segments 0000001_1 ("0", dp off) when active.
REQ-027 Load 0x0999, HEX_MODE=0, en_in=1 -> after 2 cycles count_out=0x1000; no overflow_out.
REQ-028 Load 0x9999, HEX_MODE=0, en_in=1 -> count_out=0x0000 and overflow_out high exactly 1 cycle.
REQ-029 HEX_MODE=1, load 0x00FF, increment -> 0x0100; digit showing 0xA yields segments 0001000 (active-low a..g).
REQ-030 clear_in and load_in asserted together with load_value 0x1234 -> count_out=0x0000; rst_n_in pulsed low mid-slot -> outputs immediately all 1, scan restarts at digit 0.
REQ-031 With SEG_LEADING_ZERO_BLANK_EN, value 0x0042 -> digits 3,2 blank, digits 1,0 show "4","2"; value 0 -> only digit 0 shows "0".

Source files
------------

// File: rtl/seg_scan_counter.sv
// Multiplexed seven-segment scanner with a ripple BCD/hex counter.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_counter #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16,
  parameter int TICK_DIV     = 12000000,
  parameter int HEX_MODE     = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic                  clear_in,
  input  logic                  load_in,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     digit_select,
  output logic [7:0]            led_segments,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  overflow_out
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] DIGIT_MAX = (HEX_MODE != 0) ? 4'd15 : 4'd9;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] value_q, value_d, inc_val;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic                ovf_q, ovf_d;
  logic                inc_carry;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          cur_nib;

  // Active-high {a..g} glyph; undefined digits in decimal mode stay dark.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;  4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;  4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;  default: g = 7'b1000111;
    endcase
    if ((HEX_MODE == 0) && (n > 4'd9)) g = 7'b0000000;
    return g;
  endfunction

  // Digits at or above the base limit (including loaded 10..15 in decimal) wrap with carry.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    inc_val = value_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] >= DIGIT_MAX) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    inc_carry = carry;
  end

  always_comb begin
    value_d = value_q;
    tick_d  = tick_q;
    ovf_d   = 1'b0;
    if (clear_in) begin
      value_d = '0;
      tick_d  = '0;
    end else if (load_in) begin
      value_d = load_value;
      tick_d  = '0;
    end else if (en_in) begin
      if (tick_q == TICK_W'(TICK_DIV - 1)) begin
        tick_d  = '0;
        value_d = inc_val;
        ovf_d   = inc_carry;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    ref_d  = ref_q + 1'b1;
    scan_d = scan_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      scan_d = (scan_q == SCAN_W'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (value_q[4*i +: 4] != 4'd0) seen = 1'b1;
      lz_blank[i] = !seen;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_nib = value_q[4*int'(scan_q) +: 4];

  always_comb begin
    sel_d = '0;
    seg_d = '0;
    if (ref_q >= REF_W'(BLANK_CYCLES)) begin
      sel_d[scan_q] = 1'b1;
      seg_d = {(lz_blank[scan_q] ? 7'b0000000 : glyph(cur_nib)), dp_in[scan_q]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      value_q <= '0;
      tick_q  <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      scan_q  <= '0;
      sel_q   <= {DIGITS{POL}};
      seg_q   <= {8{POL}};
    end else begin
      value_q <= value_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d ^ {DIGITS{POL}};
      seg_q   <= seg_d ^ {8{POL}};
    end
  end

  assign digit_select = sel_q;
  assign led_segments = seg_q;
  assign count_out    = value_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Bench for seg_scan_counter: a decimal and a hex instance driven in parallel against a reference model.
module tb_seg_scan_counter;
  localparam int D = 4, RD = 4, BC = 1, TD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [15:0] lv = '0;
  logic [3:0] dp = '0;
  logic [3:0] sel0, sel1;
  logic [7:0] seg0, seg1;
  logic [15:0] cnt0, cnt1;
  logic ovf0, ovf1;

  int checks = 0;
  int failures = 0;

  logic [15:0] mv [2];
  logic mo [2];
  int mtick = 0;
  int edges = 0;
  logic [3:0] esel;
  logic [7:0] eseg [2];

  seg_scan_counter #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .TICK_DIV(TD),
                     .HEX_MODE(0), .ACTIVE_LOW(1)) u_dec (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .clear_in(clr), .load_in(ld),
    .load_value(lv), .dp_in(dp), .digit_select(sel0), .led_segments(seg0),
    .count_out(cnt0), .overflow_out(ovf0));

  seg_scan_counter #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .TICK_DIV(TD),
                     .HEX_MODE(1), .ACTIVE_LOW(1)) u_hex (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .clear_in(clr), .load_in(ld),
    .load_value(lv), .dp_in(dp), .digit_select(sel1), .led_segments(seg1),
    .count_out(cnt1), .overflow_out(ovf1));

  always #5 clk = ~clk;

  function automatic logic [6:0] gly(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return t[n];
  endfunction

  function automatic logic [7:0] exp_seg(input int m, input logic [15:0] v, input int slot,
                                         input logic dpb);
    logic [3:0] n;
    logic [6:0] g;
    n = v[4*slot +: 4];
    g = gly(n);
    if (m == 0 && n > 4'd9) g = 7'd0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (slot > 0 && (v >> (4*slot)) == 16'd0) g = 7'd0;
`endif
    return ~{g, dpb};
  endfunction

  function automatic logic [16:0] inc_model(input int m, input logic [15:0] v);
    int base;
    logic [15:0] r;
    base = (m != 0) ? 16 : 10;
    r = v;
    for (int i = 0; i < D; i++) begin
      if (int'(v[4*i +: 4]) + 1 >= base) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        return {1'b0, r};
      end
    end
    return {1'b1, r};
  endfunction

  task automatic reset_model();
    mv[0] = '0; mv[1] = '0; mo[0] = 1'b0; mo[1] = 1'b0;
    mtick = 0; edges = 0;
  endtask

  // One clock: predict display from pre-edge state, clock, advance model, settle.
  task automatic step();
    int r, s;
    r = edges % RD;
    s = (edges / RD) % D;
    if (r < BC) begin
      esel = 4'hF; eseg[0] = 8'hFF; eseg[1] = 8'hFF;
    end else begin
      esel = ~(4'b0001 << s);
      for (int m = 0; m < 2; m++) eseg[m] = exp_seg(m, mv[m], s, dp[s]);
    end
    @(posedge clk);
    edges++;
    mo[0] = 1'b0; mo[1] = 1'b0;
    if (clr) begin
      mv[0] = '0; mv[1] = '0; mtick = 0;
    end else if (ld) begin
      mv[0] = lv; mv[1] = lv; mtick = 0;
    end else if (en) begin
      if (mtick == TD - 1) begin
        mtick = 0;
        for (int m = 0; m < 2; m++) {mo[m], mv[m]} = inc_model(m, mv[m]);
      end else begin
        mtick++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({sel0, seg0, cnt0, ovf0, sel1, seg1, cnt1, ovf1} !== {4'hF, 8'hFF, 16'h0, 1'b0, 4'hF, 8'hFF, 16'h0, 1'b0}) begin
        failures++;
        $display("FAIL reset got=%h/%h/%h/%b %h/%h/%h/%b exp=F/FF/0000/0", sel0, seg0, cnt0, ovf0, sel1, seg1, cnt1, ovf1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk) rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_scan();
    en = 1'b0; dp = 4'h0;
    for (int k = 0; k < 32; k++) begin
      step();
      checks++;
      if ({sel0, seg0, cnt0, ovf0} !== {esel, eseg[0], mv[0], mo[0]}) begin
        failures++;
        $display("FAIL scan_dec k=%0d got=%h %h %h %b exp=%h %h %h %b", k, sel0, seg0, cnt0, ovf0, esel, eseg[0], mv[0], mo[0]);
      end
      checks++;
      if ({sel1, seg1, cnt1, ovf1} !== {esel, eseg[1], mv[1], mo[1]}) begin
        failures++;
        $display("FAIL scan_hex k=%0d got=%h %h %h %b exp=%h %h %h %b", k, sel1, seg1, cnt1, ovf1, esel, eseg[1], mv[1], mo[1]);
      end
      if (k == 0) begin
        checks++;
        if (sel0 !== 4'hF) begin
          failures++; $display("FAIL scan_first_blank got=%h exp=F", sel0);
        end
      end
      if (k == 1) begin
        checks++;
        if ({sel0, seg0} !== {4'hE, 8'b0000_0011}) begin
          failures++; $display("FAIL scan_digit0 got=%h %h exp=E 03", sel0, seg0);
        end
      end
    end
  endtask

  task automatic test_decimal_carry();
    ld = 1'b1; lv = 16'h0999; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ld = 1'b0;
      checks++;
      if ({sel0, seg0, cnt0, ovf0, sel1, seg1, cnt1, ovf1} !== {esel, eseg[0], mv[0], mo[0], esel, eseg[1], mv[1], mo[1]}) begin
        failures++;
        $display("FAIL carry_model k=%0d got=%h %h %h %b exp=%h %h %h %b", k, sel0, seg0, cnt0, ovf0, esel, eseg[0], mv[0], mo[0]);
      end
    end
    checks++;
    if ({cnt0, ovf0, cnt1} !== {16'h1000, 1'b0, 16'h099A}) begin
      failures++; $display("FAIL carry_0999 got=%h %b %h exp=1000 0 099a", cnt0, ovf0, cnt1);
    end
  endtask

  task automatic test_overflow();
    ld = 1'b1; lv = 16'h9999; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      ld = 1'b0;
      checks++;
      if ({cnt0, ovf0, cnt1, ovf1} !== {mv[0], mo[0], mv[1], mo[1]}) begin
        failures++;
        $display("FAIL ovf_model k=%0d got=%h %b %h %b exp=%h %b %h %b", k, cnt0, ovf0, cnt1, ovf1, mv[0], mo[0], mv[1], mo[1]);
      end
      if (k == 2) begin
        checks++;
        if ({cnt0, ovf0, ovf1} !== {16'h0000, 1'b1, 1'b0}) begin
          failures++; $display("FAIL ovf_wrap got=%h %b %b exp=0000 1 0", cnt0, ovf0, ovf1);
        end
      end
      if (k == 3) begin
        checks++;
        if (ovf0 !== 1'b0) begin
          failures++; $display("FAIL ovf_single got=%b exp=0", ovf0);
        end
      end
    end
  endtask

  task automatic test_hex();
    int seen;
    seen = 0;
    ld = 1'b1; lv = 16'h00FF; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ld = 1'b0;
    end
    checks++;
    if ({cnt1, cnt0} !== {16'h0100, 16'h0100}) begin
      failures++; $display("FAIL hex_00ff got=%h %h exp=0100 0100", cnt1, cnt0);
    end
    ld = 1'b1; lv = 16'h000A; en = 1'b0; dp = 4'h0;
    for (int k = 0; k < 16; k++) begin
      step();
      ld = 1'b0;
      checks++;
      if ({sel0, seg0, sel1, seg1} !== {esel, eseg[0], esel, eseg[1]}) begin
        failures++;
        $display("FAIL hex_disp k=%0d got=%h %h %h %h exp=%h %h %h %h", k, sel0, seg0, sel1, seg1, esel, eseg[0], esel, eseg[1]);
      end
      if (sel1 == 4'hE) begin
        seen++;
        checks++;
        if (seg1[7:1] !== 7'b0001000) begin
          failures++; $display("FAIL hex_glyph_a got=%b exp=0001000", seg1[7:1]);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      failures++; $display("FAIL hex_digit0_shown got=0 exp>0");
    end
  endtask

  task automatic test_clear_priority();
    ld = 1'b1; lv = 16'h5555; en = 1'b1;
    step();
    clr = 1'b1; lv = 16'h1234;
    step();
    clr = 1'b0; ld = 1'b0;
    checks++;
    if ({cnt0, cnt1, ovf0, sel0, seg0} !== {16'h0, 16'h0, 1'b0, esel, eseg[0]}) begin
      failures++;
      $display("FAIL clear_over_load got=%h %h %b %h %h exp=0000 0000 0 %h %h", cnt0, cnt1, ovf0, sel0, seg0, esel, eseg[0]);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    for (int k = 0; k < 12 && (edges % RD) != 2; k++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel0, seg0, sel1, seg1, cnt0, ovf0} !== {4'hF, 8'hFF, 4'hF, 8'hFF, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got=%h %h %h %h %h %b exp=F FF F FF 0000 0", sel0, seg0, sel1, seg1, cnt0, ovf0);
    end
    @(negedge clk) rst_n = 1'b1;
    reset_model();
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({sel0, seg0, cnt0, sel1, seg1} !== {esel, eseg[0], mv[0], esel, eseg[1]}) begin
        failures++;
        $display("FAIL reset_restart k=%0d got=%h %h %h exp=%h %h %h", k, sel0, seg0, cnt0, esel, eseg[0], mv[0]);
      end
    end
  endtask

  task automatic test_leading();
    ld = 1'b1; lv = 16'h0042; en = 1'b0; dp = 4'b0100;
    for (int k = 0; k < 34; k++) begin
      step();
      ld = 1'b0;
      if (k == 17) clr = 1'b1;
      else clr = 1'b0;
      checks++;
      if ({sel0, seg0, sel1, seg1} !== {esel, eseg[0], esel, eseg[1]}) begin
        failures++;
        $display("FAIL leading k=%0d got=%h %h %h %h exp=%h %h %h %h", k, sel0, seg0, sel1, seg1, esel, eseg[0], esel, eseg[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 99) < 3);
      ld  = ($urandom_range(0, 99) < 6);
      lv  = ($urandom_range(0, 1) == 1) ? 16'(16'h9990 | 16'($urandom_range(0, 15))) : 16'($urandom);
      dp  = 4'($urandom);
      step();
      checks++;
      if ({sel0, seg0, cnt0, ovf0} !== {esel, eseg[0], mv[0], mo[0]}) begin
        failures++;
        $display("FAIL rand_dec k=%0d got=%h %h %h %b exp=%h %h %h %b", k, sel0, seg0, cnt0, ovf0, esel, eseg[0], mv[0], mo[0]);
      end
      checks++;
      if ({sel1, seg1, cnt1, ovf1} !== {esel, eseg[1], mv[1], mo[1]}) begin
        failures++;
        $display("FAIL rand_hex k=%0d got=%h %h %h %b exp=%h %h %h %b", k, sel1, seg1, cnt1, ovf1, esel, eseg[1], mv[1], mo[1]);
      end
    end
    en = 1'b0; clr = 1'b0; ld = 1'b0;
  endtask

  initial begin
    reset_model();
    test_reset();
    test_scan();
    test_decimal_carry();
    test_overflow();
    test_hex();
    test_clear_priority();
    test_reset_mid();
    test_leading();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
